// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and defaults for the permanent-fault tracker.
// Each replica's health is an FT_* state plus a leaky error counter.
package cv32e40p_ft_pkg;

  localparam int FT_N_ALU     = 4;
  localparam int FT_N_MULT    = 3;
  localparam int FT_CNT_W     = 6;
  localparam int FT_THRESHOLD = 16;
  localparam int FT_DECAY_W   = 12;
  localparam int FT_MAX_REPL  = 8;

  typedef enum logic [1:0] {
    FT_OK      = 2'd0,
    FT_SUSPECT = 2'd1,
    FT_FAULTY  = 2'd2
  } ft_health_e;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic ft_multi_hot(input logic [FT_MAX_REPL-1:0] v);
    return |(v & (v - 8'd1));
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter_ft.sv
// Health FSM and saturating leaky counter for one replica.
// A FAULTY replica stays faulty until clear or reset.
module cv32e40p_ft_err_counter_ft
  import cv32e40p_ft_pkg::*;
#(
  parameter int CNT_W     = FT_CNT_W,
  parameter int THRESHOLD = FT_THRESHOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  input  logic       dec,
  output ft_health_e state,
  output logic       faulty,
  output logic       rise
);

  localparam logic [CNT_W-1:0] L_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_THR  = CNT_W'(THRESHOLD);

  ft_health_e       r_state;
  ft_health_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FT_OK;
      r_cnt   <= L_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: clear wins; an error and a decay tick together cancel out
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = FT_OK;
      w_cnt_nxt   = L_ZERO;
    end else begin
      case (r_state)
        FT_OK: begin
          if (inc) begin
            w_cnt_nxt   = L_ONE;
            w_state_nxt = (L_ONE == L_THR) ? FT_FAULTY : FT_SUSPECT;
          end else begin
            w_cnt_nxt   = L_ZERO;
            w_state_nxt = FT_OK;
          end
        end
        FT_SUSPECT: begin
          if (inc && !dec) begin
            w_cnt_nxt   = r_cnt + L_ONE;
            w_state_nxt = ((r_cnt + L_ONE) == L_THR) ? FT_FAULTY : FT_SUSPECT;
          end else if (dec && !inc) begin
            w_cnt_nxt   = r_cnt - L_ONE;
            w_state_nxt = (r_cnt == L_ONE) ? FT_OK : FT_SUSPECT;
          end else begin
            w_cnt_nxt   = r_cnt;
            w_state_nxt = FT_SUSPECT;
          end
        end
        FT_FAULTY: begin
          w_cnt_nxt   = r_cnt;
          w_state_nxt = FT_FAULTY;
        end
        default: begin
          w_cnt_nxt   = L_ZERO;
          w_state_nxt = FT_OK;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; rise flags the edge into FAULTY
  always_comb begin
    state  = r_state;
    faulty = (r_state == FT_FAULTY);
    rise   = (w_state_nxt == FT_FAULTY) && (r_state != FT_FAULTY);
  end

endmodule

// File: rtl/cv32e40p_perm_fault_tracker_ft.sv
// Turns per-cycle voter disagreements into sticky per-replica faulty flags
// for the ALU/MULT replica dispatcher and the CSR interface.
module cv32e40p_perm_fault_tracker_ft
  import cv32e40p_ft_pkg::*;
#(
  parameter int N_ALU     = FT_N_ALU,
  parameter int N_MULT    = FT_N_MULT,
  parameter int CNT_W     = FT_CNT_W,
  parameter int THRESHOLD = FT_THRESHOLD,
  parameter int DECAY_W   = FT_DECAY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_vote_valid_i,
  input  logic [N_ALU-1:0]  alu_err_i,
  input  logic              mult_vote_valid_i,
  input  logic [N_MULT-1:0] mult_err_i,
  input  logic              clear_i,
  output logic [N_ALU-1:0]  permanent_faulty_alu_o,
  output logic [N_MULT-1:0] permanent_faulty_mult_o,
  output logic              new_fault_o,
  output logic              no_majority_o,
  output logic [N_ALU-1:0]  alu_suspect_o,
  output logic [N_MULT-1:0] mult_suspect_o
);

  logic [DECAY_W-1:0]     r_decay_cnt;
  logic                   w_tick;
  logic [N_ALU-1:0]       w_alu_faulty;
  logic [N_ALU-1:0]       w_alu_masked;
  logic [N_ALU-1:0]       w_alu_inc;
  logic [N_ALU-1:0]       w_alu_rise;
  logic [N_ALU-1:0]       w_alu_suspect;
  logic [N_MULT-1:0]      w_mult_faulty;
  logic [N_MULT-1:0]      w_mult_masked;
  logic [N_MULT-1:0]      w_mult_inc;
  logic [N_MULT-1:0]      w_mult_rise;
  logic [N_MULT-1:0]      w_mult_suspect;
  logic [FT_MAX_REPL-1:0] w_alu_ext;
  logic [FT_MAX_REPL-1:0] w_mult_ext;
  logic                   w_alu_multi;
  logic                   w_mult_multi;
  logic                   w_alu_nm;
  logic                   w_mult_nm;
  ft_health_e             w_alu_state  [N_ALU];
  ft_health_e             w_mult_state [N_MULT];
  logic                   r_new_fault;
  logic                   r_no_majority;

  // Free-running decay window, restarted by software clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decay_cnt <= {DECAY_W{1'b0}};
    end else if (clear_i) begin
      r_decay_cnt <= {DECAY_W{1'b0}};
    end else begin
      r_decay_cnt <= r_decay_cnt + DECAY_W'(1);
    end
  end

  assign w_tick = &r_decay_cnt;

  // Majority masking: already-faulty replicas are ignored, and only a lone dissenter is charged
  always_comb begin
    w_alu_masked  = alu_err_i & ~w_alu_faulty;
    w_mult_masked = mult_err_i & ~w_mult_faulty;
    w_alu_ext                = {FT_MAX_REPL{1'b0}};
    w_alu_ext[N_ALU-1:0]     = w_alu_masked;
    w_mult_ext               = {FT_MAX_REPL{1'b0}};
    w_mult_ext[N_MULT-1:0]   = w_mult_masked;
    w_alu_multi  = ft_multi_hot(w_alu_ext);
    w_mult_multi = ft_multi_hot(w_mult_ext);
    w_alu_nm     = alu_vote_valid_i & w_alu_multi;
    w_mult_nm    = mult_vote_valid_i & w_mult_multi;
    if (alu_vote_valid_i && !w_alu_multi) begin
      w_alu_inc = w_alu_masked;
    end else begin
      w_alu_inc = {N_ALU{1'b0}};
    end
    if (mult_vote_valid_i && !w_mult_multi) begin
      w_mult_inc = w_mult_masked;
    end else begin
      w_mult_inc = {N_MULT{1'b0}};
    end
  end

  for (genvar g = 0; g < N_ALU; g++) begin : g_alu
    cv32e40p_ft_err_counter_ft #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_i),
      .inc    (w_alu_inc[g]),
      .dec    (w_tick),
      .state  (w_alu_state[g]),
      .faulty (w_alu_faulty[g]),
      .rise   (w_alu_rise[g])
    );
    assign w_alu_suspect[g] = (w_alu_state[g] == FT_SUSPECT);
  end

  for (genvar g = 0; g < N_MULT; g++) begin : g_mult
    cv32e40p_ft_err_counter_ft #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_i),
      .inc    (w_mult_inc[g]),
      .dec    (w_tick),
      .state  (w_mult_state[g]),
      .faulty (w_mult_faulty[g]),
      .rise   (w_mult_rise[g])
    );
    assign w_mult_suspect[g] = (w_mult_state[g] == FT_SUSPECT);
  end

  // Event pulses, visible the cycle after the vote that caused them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_new_fault   <= 1'b0;
      r_no_majority <= 1'b0;
    end else if (clear_i) begin
      r_new_fault   <= 1'b0;
      r_no_majority <= 1'b0;
    end else begin
      r_new_fault   <= (|w_alu_rise) | (|w_mult_rise);
      r_no_majority <= w_alu_nm | w_mult_nm;
    end
  end

  assign permanent_faulty_alu_o  = w_alu_faulty;
  assign permanent_faulty_mult_o = w_mult_faulty;
  assign alu_suspect_o           = w_alu_suspect;
  assign mult_suspect_o          = w_mult_suspect;
  assign new_fault_o             = r_new_fault;
  assign no_majority_o           = r_no_majority;

endmodule

// File: tb/tb_cv32e40p_perm_fault_tracker_ft.sv
// Self-checking bench: three tracker instances (slow decay, fast decay, threshold 1)
// share one stimulus stream and are compared every cycle against a counting model.
module tb_cv32e40p_perm_fault_tracker_ft;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_vote_valid_i;
  logic [3:0] alu_err_i;
  logic       mult_vote_valid_i;
  logic [2:0] mult_err_i;
  logic       clear_i;

  logic [3:0] fa [NI];
  logic [2:0] fm [NI];
  logic       nf [NI];
  logic       nm [NI];
  logic [3:0] sa [NI];
  logic [2:0] sm [NI];

  int n_checks;
  int n_fail;

  // model state: replica 0..3 = ALU, 4..6 = MULT
  int m_cnt [NI][7];
  bit m_flt [NI][7];
  int m_dec [NI];
  bit m_nf  [NI];
  bit m_nm  [NI];

  always #5 clk = ~clk;

  cv32e40p_perm_fault_tracker_ft #(.THRESHOLD(16), .DECAY_W(12)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .alu_vote_valid_i(alu_vote_valid_i), .alu_err_i(alu_err_i),
    .mult_vote_valid_i(mult_vote_valid_i), .mult_err_i(mult_err_i), .clear_i(clear_i),
    .permanent_faulty_alu_o(fa[0]), .permanent_faulty_mult_o(fm[0]), .new_fault_o(nf[0]),
    .no_majority_o(nm[0]), .alu_suspect_o(sa[0]), .mult_suspect_o(sm[0]));

  cv32e40p_perm_fault_tracker_ft #(.THRESHOLD(16), .DECAY_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .alu_vote_valid_i(alu_vote_valid_i), .alu_err_i(alu_err_i),
    .mult_vote_valid_i(mult_vote_valid_i), .mult_err_i(mult_err_i), .clear_i(clear_i),
    .permanent_faulty_alu_o(fa[1]), .permanent_faulty_mult_o(fm[1]), .new_fault_o(nf[1]),
    .no_majority_o(nm[1]), .alu_suspect_o(sa[1]), .mult_suspect_o(sm[1]));

  cv32e40p_perm_fault_tracker_ft #(.THRESHOLD(1), .DECAY_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .alu_vote_valid_i(alu_vote_valid_i), .alu_err_i(alu_err_i),
    .mult_vote_valid_i(mult_vote_valid_i), .mult_err_i(mult_err_i), .clear_i(clear_i),
    .permanent_faulty_alu_o(fa[2]), .permanent_faulty_mult_o(fm[2]), .new_fault_o(nf[2]),
    .no_majority_o(nm[2]), .alu_suspect_o(sa[2]), .mult_suspect_o(sm[2]));

  function automatic int th_of(input int k);
    return (k == 2) ? 1 : 16;
  endfunction

  function automatic int dw_of(input int k);
    return (k == 0) ? 12 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, k, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit va, input logic [3:0] ea, input bit vm, input logic [2:0] em, input bit clr);
    alu_vote_valid_i  = va;
    alu_err_i         = ea;
    mult_vote_valid_i = vm;
    mult_err_i        = em;
    clear_i           = clr;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 7; i++) begin
        m_cnt[k][i] = 0;
        m_flt[k][i] = 1'b0;
      end
      m_dec[k] = 0;
      m_nf[k]  = 1'b0;
      m_nm[k]  = 1'b0;
    end
  endtask

  // one clock edge of the health rules, using the inputs currently applied
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit tick, rose, nomaj, e, gv;
      logic [3:0] ge;
      int nerr, nr, base, idx;
      if (clear_i) begin
        for (int i = 0; i < 7; i++) begin
          m_cnt[k][i] = 0;
          m_flt[k][i] = 1'b0;
        end
        m_dec[k] = 0;
        m_nf[k]  = 1'b0;
        m_nm[k]  = 1'b0;
      end else begin
        tick = (m_dec[k] == (1 << dw_of(k)) - 1);
        m_dec[k] = (m_dec[k] + 1) % (1 << dw_of(k));
        rose = 1'b0;
        nomaj = 1'b0;
        for (int g = 0; g < 2; g++) begin
          gv   = (g == 0) ? alu_vote_valid_i : mult_vote_valid_i;
          ge   = (g == 0) ? alu_err_i : {1'b0, mult_err_i};
          nr   = (g == 0) ? 4 : 3;
          base = (g == 0) ? 0 : 4;
          nerr = 0;
          for (int i = 0; i < nr; i++) if (ge[i] && !m_flt[k][base+i]) nerr++;
          if (gv && nerr >= 2) nomaj = 1'b1;
          for (int i = 0; i < nr; i++) begin
            idx = base + i;
            e = gv && ge[i] && !m_flt[k][idx] && (nerr == 1);
            if (!m_flt[k][idx]) begin
              if (m_cnt[k][idx] == 0) begin
                if (e) m_cnt[k][idx] = 1;
              end else if (e && !tick) begin
                m_cnt[k][idx]++;
              end else if (!e && tick) begin
                m_cnt[k][idx]--;
              end
              if (m_cnt[k][idx] == th_of(k)) begin
                m_flt[k][idx] = 1'b1;
                rose = 1'b1;
              end
            end
          end
        end
        m_nf[k] = rose;
        m_nm[k] = nomaj;
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < NI; k++) begin
      logic [3:0] efa, esa;
      logic [2:0] efm, esm;
      for (int i = 0; i < 4; i++) begin
        efa[i] = m_flt[k][i];
        esa[i] = (m_cnt[k][i] != 0) && !m_flt[k][i];
      end
      for (int i = 0; i < 3; i++) begin
        efm[i] = m_flt[k][4+i];
        esm[i] = (m_cnt[k][4+i] != 0) && !m_flt[k][4+i];
      end
      chk("model_faulty_alu", k, {4'h0, fa[k]}, {4'h0, efa});
      chk("model_faulty_mult", k, {5'h0, fm[k]}, {5'h0, efm});
      chk("model_suspect_alu", k, {4'h0, sa[k]}, {4'h0, esa});
      chk("model_suspect_mult", k, {5'h0, sm[k]}, {5'h0, esm});
      chk("model_new_fault", k, {7'h0, nf[k]}, {7'h0, m_nf[k]});
      chk("model_no_majority", k, {7'h0, nm[k]}, {7'h0, m_nm[k]});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_check();
  endtask

  task automatic repeat_in(input int n, input bit va, input logic [3:0] ea, input bit vm, input logic [2:0] em);
    set_in(va, ea, vm, em, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    bit va; logic [3:0] ea; bit vm; logic [2:0] em; bit clr;
    logic [3:0] x_fa; logic [2:0] x_fm; bit x_nf; bit x_nm; logic [3:0] x_sa; logic [2:0] x_sm;
  } vec_t;

  vec_t tbl [9];
  int   nf_count;
  bit   late;
  int   r;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    set_in(1'b0, 4'h0, 1'b0, 3'h0, 1'b0);

    // expected outputs of the slow-decay instance straight after reset
    tbl[0] = '{1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000};
    tbl[1] = '{1'b1, 4'b0001, 1'b0, 3'b000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0001, 3'b000};
    tbl[2] = '{1'b1, 4'b0011, 1'b0, 3'b000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 4'b0001, 3'b000};
    tbl[3] = '{1'b0, 4'b0000, 1'b1, 3'b100, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0001, 3'b100};
    tbl[4] = '{1'b0, 4'b0001, 1'b0, 3'b000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0001, 3'b100};
    tbl[5] = '{1'b1, 4'b0010, 1'b0, 3'b000, 1'b1, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000};
    tbl[6] = '{1'b1, 4'b0000, 1'b0, 3'b000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000, 3'b000};
    tbl[7] = '{1'b0, 4'b0000, 1'b1, 3'b011, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 4'b0000, 3'b000};
    tbl[8] = '{1'b1, 4'b1000, 1'b1, 3'b001, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b1000, 3'b001};

    do_reset();
    chk("reset_faulty_alu", 0, {4'h0, fa[0]}, 8'h00);
    chk("reset_new_fault", 0, {7'h0, nf[0]}, 8'h00);

    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].va, tbl[i].ea, tbl[i].vm, tbl[i].em, tbl[i].clr);
      cycle();
      chk("tbl_faulty_alu", 0, {4'h0, fa[0]}, {4'h0, tbl[i].x_fa});
      chk("tbl_faulty_mult", 0, {5'h0, fm[0]}, {5'h0, tbl[i].x_fm});
      chk("tbl_new_fault", 0, {7'h0, nf[0]}, {7'h0, tbl[i].x_nf});
      chk("tbl_no_majority", 0, {7'h0, nm[0]}, {7'h0, tbl[i].x_nm});
      chk("tbl_suspect_alu", 0, {4'h0, sa[0]}, {4'h0, tbl[i].x_sa});
      chk("tbl_suspect_mult", 0, {5'h0, sm[0]}, {5'h0, tbl[i].x_sm});
    end

    // ALU2 reaches threshold on the 16th vote, then stays faulty with one pulse
    do_reset();
    repeat_in(15, 1'b1, 4'b0100, 1'b0, 3'b000);
    chk("thr_before_faulty", 0, {4'h0, fa[0]}, 8'h00);
    chk("thr_before_suspect", 0, {4'h0, sa[0]}, 8'h04);
    cycle();
    chk("thr_faulty", 0, {4'h0, fa[0]}, 8'h04);
    chk("thr_pulse", 0, {7'h0, nf[0]}, 8'h01);
    chk("thr_suspect_drop", 0, {4'h0, sa[0]}, 8'h00);
    nf_count = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      nf_count += int'(nf[0]);
    end
    chk("thr_single_pulse", 0, nf_count[7:0], 8'h01);
    chk("thr_sticky", 0, {4'h0, fa[0]}, 8'h04);

    // a faulty ALU1 is masked, so 0011 charges ALU0 alone
    do_reset();
    repeat_in(16, 1'b1, 4'b0010, 1'b0, 3'b000);
    repeat_in(1, 1'b1, 4'b0011, 1'b0, 3'b000);
    chk("mask_no_majority", 0, {7'h0, nm[0]}, 8'h00);
    chk("mask_suspect", 0, {4'h0, sa[0]}, 8'h01);
    chk("mask_faulty", 0, {4'h0, fa[0]}, 8'h02);

    // clear beats the 16th ALU3 error
    do_reset();
    repeat_in(16, 1'b1, 4'b0001, 1'b0, 3'b000);
    repeat_in(15, 1'b1, 4'b1000, 1'b0, 3'b000);
    chk("clr_pre_suspect", 0, {4'h0, sa[0]}, 8'h08);
    set_in(1'b1, 4'b1000, 1'b0, 3'b000, 1'b1);
    cycle();
    chk("clr_faulty", 0, {4'h0, fa[0]}, 8'h00);
    chk("clr_suspect", 0, {4'h0, sa[0]}, 8'h00);
    chk("clr_no_pulse", 0, {7'h0, nf[0]}, 8'h00);
    repeat_in(1, 1'b0, 4'b0000, 1'b0, 3'b000);
    chk("clr_no_late_pulse", 0, {7'h0, nf[0]}, 8'h00);
    repeat_in(15, 1'b1, 4'b1000, 1'b0, 3'b000);
    chk("clr_count_restart", 0, {4'h0, fa[0]}, 8'h00);

    // fast decay: MULT0 at 3 drains over three ticks
    do_reset();
    repeat_in(3, 1'b0, 4'b0000, 1'b1, 3'b001);
    chk("decay_suspect", 1, {5'h0, sm[1]}, 8'h01);
    repeat_in(20, 1'b0, 4'b0000, 1'b0, 3'b000);
    chk("decay_still_suspect", 1, {5'h0, sm[1]}, 8'h01);
    repeat_in(4, 1'b0, 4'b0000, 1'b0, 3'b000);
    chk("decay_ok", 1, {5'h0, sm[1]}, 8'h00);
    chk("decay_not_faulty", 1, {5'h0, fm[1]}, 8'h00);

    // error coinciding with a tick leaves MULT1's count alone (cycles 7 and 15)
    do_reset();
    repeat_in(5, 1'b0, 4'b0000, 1'b1, 3'b010);
    repeat_in(2, 1'b0, 4'b0000, 1'b0, 3'b000);
    repeat_in(12, 1'b0, 4'b0000, 1'b1, 3'b010);
    chk("tickinc_not_yet", 1, {5'h0, fm[1]}, 8'h00);
    repeat_in(1, 1'b0, 4'b0000, 1'b1, 3'b010);
    chk("tickinc_faulty", 1, {5'h0, fm[1]}, 8'h02);
    repeat_in(1, 1'b1, 4'b0011, 1'b0, 3'b000);
    chk("nomaj_pulse", 0, {7'h0, nm[0]}, 8'h01);
    chk("nomaj_no_count", 0, {4'h0, sa[0]}, 8'h00);
    repeat_in(1, 1'b0, 4'b0000, 1'b0, 3'b000);
    chk("nomaj_one_cycle", 0, {7'h0, nm[0]}, 8'h00);

    // asynchronous reset between edges, then the counter restarts from zero
    do_reset();
    repeat_in(10, 1'b1, 4'b0010, 1'b0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("areset_faulty_alu", k, {4'h0, fa[k]}, 8'h00);
      chk("areset_faulty_mult", k, {5'h0, fm[k]}, 8'h00);
      chk("areset_suspect_alu", k, {4'h0, sa[k]}, 8'h00);
      chk("areset_suspect_mult", k, {5'h0, sm[k]}, 8'h00);
      chk("areset_pulses", k, {6'h0, nf[k], nm[k]}, 8'h00);
    end
    model_reset();
    set_in(1'b0, 4'h0, 1'b0, 3'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_check();
    repeat_in(6, 1'b1, 4'b0010, 1'b0, 3'b000);
    chk("areset_count_zeroed", 0, {4'h0, fa[0]}, 8'h00);

    // random traffic: busy with occasional clears, then sparse without clears
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      late = (c >= 3000);
      r = int'($urandom_range(0, 15));
      if (r < 10) alu_err_i = 4'b0001 << $urandom_range(0, 3);
      else if (r < 13) alu_err_i = 4'b0000;
      else alu_err_i = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 15));
      if (r < 10) mult_err_i = 3'b001 << $urandom_range(0, 2);
      else if (r < 13) mult_err_i = 3'b000;
      else mult_err_i = 3'($urandom_range(0, 7));
      if (late) begin
        alu_vote_valid_i  = ($urandom_range(0, 63) == 0);
        mult_vote_valid_i = ($urandom_range(0, 63) == 0);
        clear_i = 1'b0;
      end else begin
        alu_vote_valid_i  = 1'($urandom_range(0, 1));
        mult_vote_valid_i = 1'($urandom_range(0, 1));
        clear_i = ($urandom_range(0, 599) == 0);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
